// File: rtl/line_mem_bridge_pkg.sv
// Shared widths, state encoding and address helper for the line-to-burst memory bridge.
// coherent_cache_system and its bench reuse the width constants from here.
package line_mem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int LINE_SIZE  = 32;
  localparam int LINE_BITS  = LINE_SIZE * 8;
  localparam int BEATS      = LINE_BITS / DATA_WIDTH;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int OFFSET_W   = $clog2(LINE_SIZE);
  localparam int WORD_SH    = $clog2(DATA_WIDTH);
  localparam int LINE_IDX_W = BEAT_W + WORD_SH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Bursts always start on a line boundary, whatever offset the cache presents.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/line_mem_bridge_if.sv
// Cache-side line port plus narrow external burst bus, bundled for the bridge.
// slave = bridge view, master = cache + external memory view.
interface line_mem_bridge_if;
  import line_mem_pkg::*;

  // Cache side: mem_read/mem_write are levels held until the one-cycle mem_ready.
  // External side: a command or write beat transfers on a rising edge where its
  // valid and ready are both high; valid and payload stay stable until then.
  // ext_rvalid has no ready: each cycle it is high is one read beat.
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_BITS-1:0]  mem_write_data;
  logic [LINE_BITS-1:0]  mem_read_data;
  logic                  mem_ready;

  logic                  ext_cmd_valid;
  logic                  ext_cmd_ready;
  logic                  ext_cmd_we;
  logic [ADDR_WIDTH-1:0] ext_cmd_addr;
  logic [DATA_WIDTH-1:0] ext_wdata;
  logic                  ext_wvalid;
  logic                  ext_wready;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  ext_rvalid;

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_write_data,
    output mem_read_data, mem_ready,
    output ext_cmd_valid, ext_cmd_we, ext_cmd_addr, ext_wdata, ext_wvalid,
    input  ext_cmd_ready, ext_wready, ext_rdata, ext_rvalid
  );

  modport master (
    output mem_read, mem_write, mem_addr, mem_write_data,
    input  mem_read_data, mem_ready,
    input  ext_cmd_valid, ext_cmd_we, ext_cmd_addr, ext_wdata, ext_wvalid,
    output ext_cmd_ready, ext_wready, ext_rdata, ext_rvalid
  );

endinterface

// File: rtl/line_mem_bridge_serdes.sv
// Line serialiser/deserialiser: write-line store, read-line assembly and the beat counter.
// Word 0 (lowest bits) travels first in both directions.
module line_beat_serdes
  import line_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic                  store_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  last_o,
  output logic [DATA_WIDTH-1:0] wword_o,
  output logic [LINE_BITS-1:0]  rline_o
);

  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [LINE_BITS-1:0]  wline_q, wline_d;
  logic [LINE_BITS-1:0]  rline_q, rline_d;
  logic [LINE_IDX_W-1:0] word_lsb;

  assign word_lsb = {beat_q, {WORD_SH{1'b0}}};

  always_comb begin
    beat_d  = beat_q;
    wline_d = wline_q;
    rline_d = rline_q;
    if (load_i) begin
      wline_d = line_i;
    end
    // The counter wraps to 0 naturally on the terminal beat.
    if (clr_i) begin
      beat_d = '0;
    end else if (adv_i) begin
      beat_d = beat_q + BEAT_W'(1);
    end
    if (store_i) begin
      rline_d[word_lsb +: DATA_WIDTH] = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      beat_q  <= beat_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  assign last_o  = (beat_q == BEAT_W'(BEATS - 1));
  assign wword_o = wline_q[word_lsb +: DATA_WIDTH];
  assign rline_o = rline_q;

endmodule

// File: rtl/line_mem_bridge.sv
// Turns each cache line transfer into one burst command plus BEATS word beats,
// and reassembles read beats into a line returned with a one-cycle mem_ready.
module line_mem_bridge
  import line_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  line_mem_bridge_if.slave bus,
  output logic             busy,
  output logic             protocol_err,
  output state_e           dbg_state_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;

  logic                  load;
  logic                  clr_beat;
  logic                  adv;
  logic                  store;
  logic                  last;
  logic [DATA_WIDTH-1:0] wword;
  logic [LINE_BITS-1:0]  rline;

  line_beat_serdes u_serdes (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .line_i  (bus.mem_write_data),
    .clr_i   (clr_beat),
    .adv_i   (adv),
    .store_i (store),
    .rdata_i (bus.ext_rdata),
    .last_o  (last),
    .wword_o (wword),
    .rline_o (rline)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    load     = 1'b0;
    clr_beat = 1'b0;
    adv      = 1'b0;
    store    = 1'b0;
    case (state_q)
      // Write wins a tie; the read level stays up and is taken after RESP.
      ST_IDLE: begin
        if (bus.mem_write) begin
          addr_d  = line_align(bus.mem_addr);
          we_d    = 1'b1;
          load    = 1'b1;
          state_d = ST_CMD;
        end else if (bus.mem_read) begin
          addr_d  = line_align(bus.mem_addr);
          we_d    = 1'b0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.ext_cmd_ready) begin
          clr_beat = 1'b1;
          state_d  = we_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (bus.ext_wready) begin
          adv = 1'b1;
          if (last) state_d = ST_RESP;
        end
      end
      ST_RDATA: begin
        if (bus.ext_rvalid) begin
          store = 1'b1;
          adv   = 1'b1;
          if (last) state_d = ST_RESP;
        end
      end
      // The cache still holds its request level here, so it is not re-sampled.
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stray read beats and unsolicited command accepts are flagged, never acted upon.
  assign err_d = err_q
               | (bus.ext_rvalid    & (state_q != ST_RDATA))
               | (bus.ext_cmd_ready & (state_q != ST_CMD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign bus.ext_cmd_valid = (state_q == ST_CMD);
  assign bus.ext_cmd_we    = we_q;
  assign bus.ext_cmd_addr  = addr_q;
  assign bus.ext_wvalid    = (state_q == ST_WDATA);
  assign bus.ext_wdata     = wword;
  assign bus.mem_read_data = rline;
  assign bus.mem_ready     = (state_q == ST_RESP);
  assign busy              = (state_q != ST_IDLE);
  assign protocol_err      = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: doc/line_mem_bridge.md
Name: line_mem_bridge

Overview:
- Downstream of coherent_cache_system; consumes its line-granular memory port (mem_read/mem_write/mem_addr/mem_write_data, answers with mem_read_data/mem_ready).
- Converts each 256-bit line transfer into one burst command plus BEATS word-wide data beats on a narrow external memory bus.
- Assembles read beats into a full line and returns it with a single-cycle mem_ready pulse.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, external bus word width.
- LINE_SIZE, 32, line size in bytes.
- LINE_BITS, LINE_SIZE*8, line width in bits.
- BEATS, LINE_BITS/DATA_WIDTH (8), data beats per line.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  line read request; level, held by cache until mem_ready.
- mem_write  in  1  line write-back request; level, held until mem_ready.
- mem_addr  in  ADDR_WIDTH  line byte address.
- mem_write_data  in  LINE_BITS  write-back line.
- mem_read_data  out  LINE_BITS  assembled read line.
- mem_ready  out  1  one-cycle completion pulse.
- ext_cmd_valid  out  1  burst command valid.
- ext_cmd_ready  in  1  burst command accept.
- ext_cmd_we  out  1  1=write burst, 0=read burst.
- ext_cmd_addr  out  ADDR_WIDTH  line-aligned burst base address.
- ext_wdata  out  DATA_WIDTH  write beat data.
- ext_wvalid  out  1  write beat valid.
- ext_wready  in  1  write beat accept.
- ext_rdata  in  DATA_WIDTH  read beat data.
- ext_rvalid  in  1  read beat valid; no backpressure.
- busy  out  1  high whenever state != IDLE.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (sync, rst=1): state=IDLE, all outputs 0, mem_read_data=0, beat counter=0, protocol_err=0. Reset mid-burst aborts immediately; no mem_ready is issued.
- States: IDLE, CMD, WDATA, RDATA, RESP.
- IDLE:
  - If mem_write=1: latch mem_addr with low log2(LINE_SIZE) bits forced to 0, latch mem_write_data, set we=1, go to CMD.
  - Else if mem_read=1: latch address, set we=0, go to CMD.
  - Write has priority when both are high. The read stays pending (level) and is served after RESP.
- CMD: ext_cmd_valid=1 with latched addr/we, held stable until ext_cmd_ready. On handshake, clear beat=0 and go to WDATA (we=1) or RDATA (we=0).
- WDATA:
  - ext_wvalid=1; ext_wdata = line[beat*DATA_WIDTH +: DATA_WIDTH], low word first.
  - Each ext_wvalid&ext_wready advances beat. The handshake on beat BEATS-1 moves to RESP.
  - Stalls of any length on ext_wready are legal; data is held stable.
- RDATA:
  - Each ext_rvalid stores ext_rdata into mem_read_data[beat*DATA_WIDTH +: DATA_WIDTH] and advances beat.
  - The beat on BEATS-1 moves to RESP. Gaps between beats are legal.
- RESP: mem_ready=1 for exactly this one cycle, then IDLE. The request is not re-sampled in RESP, because the cache still drives the level request during this cycle.
- Latency with zero-wait external bus:
  - Write: CMD 1 cycle, 8 beats, RESP → mem_ready 10 cycles after the request is sampled in IDLE.
  - Read: CMD 1 cycle, plus external read latency, plus 8 beats, plus 1.
- mem_read_data holds its last assembled line until the next read overwrites it.
- Beat counter is $clog2(BEATS) bits and wraps 7→0 only on the terminal beat.
- protocol_err is set and remains set until rst when:
  - ext_rvalid=1 outside RDATA, or
  - ext_cmd_ready=1 while ext_cmd_valid=0.
  - The stray beat is ignored; state is unaffected.
- mem_addr and mem_write_data changes after capture are ignored.

Decomposition:
- Shared package line_mem_pkg: state enum (IDLE, CMD, WDATA, RDATA, RESP), default widths, and BEATS/beat-index width constants. coherent_cache_system and its testbench reuse these widths.
- Optional sub-module line_beat_serdes: holds the line register, beat counter, and word select/insert. The FSM stays in the top module.

Test Plan:
- Read, zero-wait: mem_read at 0x00001010 (memory word i = 0x1000+i*4 pattern) → ext_cmd_addr=0x00001000, we=0; 8 beats 0xA0..0xA7; mem_read_data word i = 0xA0+i; one mem_ready pulse.
- Write with stalls: mem_write at 0x00006000, line words 0xCAFEBABE+i; ext_wready toggled 1/0 → 8 ext_wdata beats in order i=0..7, each held during stalls; mem_ready exactly once, on the cycle after the last handshake.
- Simultaneous request: mem_read=mem_write=1 in same cycle → write burst first, mem_ready, then read burst begins with no further stimulus; exactly two mem_ready pulses.
- Command backpressure: ext_cmd_ready low for 5 cycles → ext_cmd_valid/addr/we stable all 5 cycles; no beats issued before the handshake.
- Stray beat: ext_rvalid=1 in IDLE → protocol_err=1 and stays 1; the following read still completes correctly.
- Reset mid-read after 3 beats: rst=1 for 1 cycle → state IDLE, mem_ready never pulses, busy=0; a new read returns a correct full line.
